// File: rtl/ccc_clkdiv_gen.sv
// ccc_clkdiv_gen: NUM_CH runtime-programmable clock-enable / divided-clock channels on the
// fabric clock, with a shadowed reconfiguration applied at the channel-0 period boundary.
module ccc_clkdiv_gen #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned DIV_W       = 5,
  parameter int unsigned RST_DIV     = 3,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ENABLE,
  input  logic                    CFG_VALID,
  output logic                    CFG_READY,
  input  logic [NUM_CH*DIV_W-1:0] CFG_DIV,
  input  logic [NUM_CH-1:0]       CFG_BYPASS,
  output logic [NUM_CH-1:0]       CE,
  output logic [NUM_CH-1:0]       DIVOUT,
  output logic                    LOCK
);

  localparam int unsigned LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_LOCKING,
    S_LOCKED,
    S_PENDING
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q     [NUM_CH];
  logic [DIV_W-1:0]  div_act_q [NUM_CH];
  logic [DIV_W-1:0]  div_shd_q [NUM_CH];
  logic [NUM_CH-1:0] byp_act_q, byp_shd_q;
  logic [NUM_CH-1:0] ce_q, divout_q, term;
  logic [LCW-1:0]    lock_cnt_q;
  logic              lock_q;
  logic              accept, apply, lock_hit;

  always_comb begin
    term = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      term[i] = (cnt_q[i] == div_act_q[i]) | byp_act_q[i];
    end
  end

  // Ready is simply "no configuration waiting in the shadow".
  assign CFG_READY = (state_q != S_PENDING);
  assign accept    = CFG_VALID & CFG_READY;
  assign apply     = (state_q == S_PENDING) & (~ENABLE | term[0]);
  assign lock_hit  = (lock_cnt_q == LCW'(LOCK_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_LOCKING;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = S_PENDING;
    end else if (apply || !ENABLE) begin
      state_d = S_LOCKING;
    end else if ((state_q == S_LOCKING) && lock_hit) begin
      state_d = S_LOCKED;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i]     <= '0;
        div_act_q[i] <= DIV_W'(RST_DIV);
        div_shd_q[i] <= DIV_W'(RST_DIV);
      end
      byp_act_q  <= '0;
      byp_shd_q  <= '0;
      ce_q       <= '0;
      divout_q   <= '0;
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else begin
      if (accept) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          div_shd_q[i] <= CFG_DIV[i*DIV_W +: DIV_W];
        end
        byp_shd_q <= CFG_BYPASS;
      end
      if (apply) begin
        div_act_q <= div_shd_q;
        byp_act_q <= byp_shd_q;
      end
      // Apply and ENABLE low share one restart path so all channels stay phase-aligned.
      if (apply || !ENABLE) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          cnt_q[i] <= '0;
        end
        ce_q       <= '0;
        divout_q   <= '0;
        lock_cnt_q <= '0;
        lock_q     <= 1'b0;
      end else begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          cnt_q[i] <= term[i] ? '0 : cnt_q[i] + DIV_W'(1);
        end
        ce_q     <= term;
        divout_q <= divout_q ^ term;
        if (!lock_hit) begin
          lock_cnt_q <= lock_cnt_q + LCW'(1);
        end
        lock_q <= lock_q | lock_hit;
      end
    end
  end

  assign CE     = ce_q;
  assign DIVOUT = divout_q;
  assign LOCK   = lock_q;

endmodule

// File: tb/tb_ccc_clkdiv_gen.sv
// Scoreboard bench for ccc_clkdiv_gen: an elapsed-cycle reference model predicts every output
// each edge, plus directed timing checks for the reconfiguration and boundary scenarios.
module tb_ccc_clkdiv_gen;
  localparam int NC = 3;
  localparam int DW = 5;
  localparam int LC = 16;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            ENABLE = 1'b0;
  logic            CFG_VALID = 1'b0;
  logic            CFG_READY;
  logic [NC*DW-1:0] CFG_DIV = '0;
  logic [NC-1:0]   CFG_BYPASS = '0;
  logic [NC-1:0]   CE;
  logic [NC-1:0]   DIVOUT;
  logic            LOCK;

  always #5 CLK = ~CLK;

  ccc_clkdiv_gen #(
    .NUM_CH(NC),
    .DIV_W(DW),
    .RST_DIV(3),
    .LOCK_CYCLES(LC)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .ENABLE(ENABLE),
    .CFG_VALID(CFG_VALID),
    .CFG_READY(CFG_READY),
    .CFG_DIV(CFG_DIV),
    .CFG_BYPASS(CFG_BYPASS),
    .CE(CE),
    .DIVOUT(DIVOUT),
    .LOCK(LOCK)
  );

  typedef struct packed {
    logic [NC-1:0] ce;
    logic [NC-1:0] dv;
    logic          lock;
    logic          rdy;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: m_t is the index of the last running edge since the last restart (-1 = none).
  int m_t = -1;
  int m_div[NC];
  bit m_byp[NC];
  int s_div[NC];
  bit s_byp[NC];
  bit m_pend = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic en, input logic vld,
                            input logic [NC*DW-1:0] div, input logic [NC-1:0] byp,
                            output exp_t e);
    int  r0, r;
    bit  acc, app;
    logic [DW-1:0] fld;
    if (rst) begin
      m_t    = -1;
      m_pend = 1'b0;
      for (int c = 0; c < NC; c++) begin
        m_div[c] = 3;
        m_byp[c] = 1'b0;
      end
    end else begin
      acc = vld && !m_pend;
      r0  = m_byp[0] ? 1 : m_div[0] + 1;
      app = m_pend && (!en || (((m_t + 1) % r0) == r0 - 1));
      if (app) begin
        for (int c = 0; c < NC; c++) begin
          m_div[c] = s_div[c];
          m_byp[c] = s_byp[c];
        end
        m_pend = 1'b0;
      end
      if (app || !en) m_t = -1;
      else            m_t = m_t + 1;
      if (acc) begin
        for (int c = 0; c < NC; c++) begin
          fld      = div[c*DW +: DW];
          s_div[c] = int'(fld);
          s_byp[c] = byp[c];
        end
        m_pend = 1'b1;
      end
    end
    e = '0;
    if (m_t >= 0) begin
      for (int c = 0; c < NC; c++) begin
        r = m_byp[c] ? 1 : m_div[c] + 1;
        e.ce[c] = ((m_t % r) == r - 1);
        e.dv[c] = (((m_t + 1) / r) % 2) == 1;
      end
      e.lock = (m_t >= LC - 1);
    end
    e.rdy = !m_pend;
  endtask

  task automatic step(input logic rst, input logic en, input logic vld,
                      input logic [NC*DW-1:0] div, input logic [NC-1:0] byp);
    exp_t e;
    @(negedge CLK);
    RST = rst; ENABLE = en; CFG_VALID = vld; CFG_DIV = div; CFG_BYPASS = byp;
    model_edge(rst, en, vld, div, byp, e);
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    check_val("ce", 32'(CE), 32'(e.ce));
    check_val("divout", 32'(DIVOUT), 32'(e.dv));
    check_val("lock", 32'(LOCK), 32'(e.lock));
    check_val("cfg_ready", 32'(CFG_READY), 32'(e.rdy));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, '0, '0);
  endtask

  function automatic logic [NC*DW-1:0] pack3(input int d0, input int d1, input int d2);
    return {DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  initial begin
    int first_ce, lock_at, n_ce1, n_ce0, n_ce2;
    int ce_k[8];
    int dv_k[8];
    int nce, ndv;
    logic prev_dv;

    // Reset and release with default ratio 4.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, '0, '0);
    check_val("rst_ce", 32'(CE), 32'd0);
    check_val("rst_lock", 32'(LOCK), 32'd0);
    check_val("rst_ready", 32'(CFG_READY), 32'd1);
    first_ce = -1; lock_at = -1; n_ce0 = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b1, 1'b0, '0, '0);
      if (CE[0]) n_ce0++;
      if (CE[0] && first_ce < 0) first_ce = k + 1;
      if (LOCK && lock_at < 0) lock_at = k + 1;
    end
    check_val("dflt_first_ce", first_ce, 4);
    check_val("dflt_lock_at", lock_at, 16);
    check_val("dflt_ce_count", n_ce0, 10);

    // Reconfigure mid-period to 0/2/31 with ch2 bypassed; a second offer must be ignored.
    idle(1);
    step(1'b0, 1'b1, 1'b1, pack3(0, 2, 31), 3'b100);
    check_val("acc_ready_low", 32'(CFG_READY), 32'd0);
    step(1'b0, 1'b1, 1'b1, pack3(7, 7, 7), 3'b000);
    check_val("pend_ready_low", 32'(CFG_READY), 32'd0);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    check_val("apply_ready", 32'(CFG_READY), 32'd1);
    check_val("apply_lock_drop", 32'(LOCK), 32'd0);
    n_ce0 = 0; n_ce1 = 0; n_ce2 = 0; lock_at = -1;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 1'b1, 1'b0, '0, '0);
      if (CE[0]) n_ce0++;
      if (CE[1]) n_ce1++;
      if (CE[2]) n_ce2++;
      if (LOCK && lock_at < 0) lock_at = k + 1;
    end
    check_val("cfgA_ce0_held", n_ce0, 30);
    check_val("cfgA_ce1_count", n_ce1, 10);
    check_val("cfgA_ce2_held", n_ce2, 30);
    check_val("cfgA_lock_at", lock_at, 16);

    // Long channel-0 period, then ENABLE dropped while a configuration is pending.
    step(1'b0, 1'b1, 1'b1, pack3(31, 4, 31), 3'b000);
    idle(10);
    step(1'b0, 1'b1, 1'b1, pack3(5, 2, 0), 3'b000);
    idle(2);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b0, '0, '0);
      check_val("enlow_ce", 32'(CE), 32'd0);
      check_val("enlow_divout", 32'(DIVOUT), 32'd0);
      check_val("enlow_lock", 32'(LOCK), 32'd0);
    end
    check_val("enlow_applied", 32'(CFG_READY), 32'd1);
    first_ce = -1; lock_at = -1;
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b1, 1'b0, '0, '0);
      if (CE[0] && first_ce < 0) first_ce = k + 1;
      if (LOCK && lock_at < 0) lock_at = k + 1;
    end
    check_val("enrise_first_ce", first_ce, 6);
    check_val("enrise_lock_at", lock_at, 16);

    // Reset while pending: shadow discarded, defaults return.
    step(1'b0, 1'b1, 1'b1, pack3(7, 7, 7), 3'b111);
    step(1'b1, 1'b1, 1'b0, '0, '0);
    check_val("rstp_ce", 32'(CE), 32'd0);
    check_val("rstp_divout", 32'(DIVOUT), 32'd0);
    check_val("rstp_lock", 32'(LOCK), 32'd0);
    check_val("rstp_ready", 32'(CFG_READY), 32'd1);
    first_ce = -1;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b1, 1'b0, '0, '0);
      if (CE[0] && first_ce < 0) first_ce = k + 1;
    end
    check_val("rstp_first_ce", first_ce, 4);

    // Maximum divider: ratio 2^DIV_W with no overflow.
    step(1'b0, 1'b1, 1'b1, pack3(31, 31, 31), 3'b000);
    idle(3);
    check_val("max_applied", 32'(CFG_READY), 32'd1);
    nce = 0; ndv = 0; prev_dv = 1'b0;
    for (int k = 0; k < 165; k++) begin
      step(1'b0, 1'b1, 1'b0, '0, '0);
      if (CE[0] && nce < 8) begin ce_k[nce] = k; nce++; end
      if (DIVOUT[0] && !prev_dv && ndv < 8) begin dv_k[ndv] = k; ndv++; end
      prev_dv = DIVOUT[0];
    end
    check_val("max_ce_count", nce, 5);
    check_val("max_first_ce", ce_k[0] + 1, 32);
    for (int j = 0; j < 4; j++) check_val("max_ce_period", ce_k[j+1] - ce_k[j], 32);
    check_val("max_dv_rises", ndv, 3);
    for (int j = 0; j < 2; j++) check_val("max_dv_period", dv_k[j+1] - dv_k[j], 64);

    // Randomised traffic checked only against the scoreboard model.
    for (int k = 0; k < 300; k++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
           pack3($urandom_range(0, 6), $urandom_range(0, 31), $urandom_range(0, 9)),
           NC'($urandom_range(0, 7) & $urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
